// File: rtl/red_pitaya_pwm_dac.sv
// -----------------------------------------------------------------------------
// red_pitaya_pwm_dac
//
// Turns one 24-bit slow-analog setting into a dithered PWM bit-stream that
// feeds an external RC filter. There is one instance per output channel.
//
// Setting word:
//   [23:16] base duty in clock counts
//   [15:0]  dither mask. Bit k adds one count to period k of the 16-period
//           frame, which gives 16x finer average resolution.
//
// Parameters:
//   PERIOD  PWM period in clk_i cycles (2..256)
//   CCW     period counter width; PERIOD-1 must fit in it
//
// Ports:
//   clk_i    clock
//   rst_i    synchronous reset, active high
//   cfg_i    setting word; it is only sampled on the first cycle of a frame
//   pwm_o    registered PWM output, with pulses left-aligned at cnt==0
//   frame_o  registered one-cycle pulse: cfg_i was captured into the shadow
// -----------------------------------------------------------------------------
module red_pitaya_pwm_dac #(
    parameter int PERIOD = 156,
    parameter int CCW    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] cfg_i,
    output logic        pwm_o,
    output logic        frame_o
);

    localparam logic [CCW-1:0] LP_LAST = CCW'(PERIOD - 1);

    logic [CCW-1:0] r_cnt;
    logic [3:0]     r_bcnt;
    logic [23:0]    r_shd;

    logic           w_load;
    logic [23:0]    w_eff;
    logic [15:0]    w_mask;
    logic [8:0]     w_duty;
    logic [8:0]     w_cnt9;

    assign w_load = (r_cnt == '0) && (r_bcnt == 4'd0);

    // On the load cycle, use cfg_i directly. This lets period 0 of the new
    // frame already run on the fresh setting, without a one-frame lag.
    assign w_eff  = w_load ? cfg_i : r_shd;
    assign w_mask = w_eff[15:0];

    // Base plus one dither count. This is a 9-bit sum, so a duty of 256 is
    // legal. Any duty >= PERIOD keeps the output high across the wrap.
    assign w_duty = {1'b0, w_eff[23:16]} + {8'd0, w_mask[r_bcnt]};
    assign w_cnt9 = 9'(r_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_bcnt  <= 4'd0;
            r_shd   <= 24'd0;
            pwm_o   <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            if (r_cnt == LP_LAST) begin
                r_cnt  <= '0;
                r_bcnt <= r_bcnt + 4'd1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end

            if (w_load) begin
                r_shd <= cfg_i;
            end
            frame_o <= w_load;
            pwm_o   <= (w_cnt9 < w_duty);
        end
    end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// -----------------------------------------------------------------------------
// Bench for red_pitaya_pwm_dac. Two instances run side by side: one uses
// PERIOD=156 and one uses PERIOD=4. Each output is compared on every cycle
// against a time-indexed model of the dithered PWM. Frame-level high counts
// come from a constant table and from hand-written corner sequences.
// -----------------------------------------------------------------------------
module tb_red_pitaya_pwm_dac;

    logic        clk_i;
    logic        rst_a, rst_b;
    logic [23:0] cfg_a, cfg_b;
    logic        pwm_a, frame_a, pwm_b, frame_b;

    red_pitaya_pwm_dac #(.PERIOD(156), .CCW(8)) dut_a (
        .clk_i  (clk_i),
        .rst_i  (rst_a),
        .cfg_i  (cfg_a),
        .pwm_o  (pwm_a),
        .frame_o(frame_a)
    );

    red_pitaya_pwm_dac #(.PERIOD(4), .CCW(2)) dut_b (
        .clk_i  (clk_i),
        .rst_i  (rst_b),
        .cfg_i  (cfg_b),
        .pwm_o  (pwm_b),
        .frame_o(frame_b)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Model state: t is the index of the next cycle since reset release.
    typedef struct {
        int          t;
        logic [23:0] shd;
        logic        pwm;
        logic        frm;
    } mstate_t;

    typedef struct {
        logic [23:0] cfg;
        int          exp_hi;
    } vec_t;

    mstate_t ma, mb;
    int      checks = 0;
    int      errors = 0;
    int      hi_a, fr_a, hi_b;

    function automatic mstate_t ref_step(input int p, input logic rst,
                                         input logic [23:0] cfg, input mstate_t s);
        mstate_t n;
        int pos, k, c, hi;
        n = s;
        if (rst) begin
            n.t = 0; n.shd = 24'd0; n.pwm = 1'b0; n.frm = 1'b0;
        end else begin
            pos = s.t % (16 * p);
            k   = pos / p;
            c   = pos % p;
            n.frm = (pos == 0);
            if (pos == 0) n.shd = cfg;
            hi    = int'(n.shd[23:16]) + int'(n.shd[k]);
            n.pwm = (c < hi);
            n.t   = s.t + 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance models on the inputs present at the edge, then compare.
    task automatic step();
        ma = ref_step(156, rst_a, cfg_a, ma);
        mb = ref_step(4,   rst_b, cfg_b, mb);
        @(posedge clk_i);
        #1;
        check("pwm_a",   32'(pwm_a),   32'(ma.pwm));
        check("frame_a", 32'(frame_a), 32'(ma.frm));
        check("pwm_b",   32'(pwm_b),   32'(mb.pwm));
        check("frame_b", 32'(frame_b), 32'(mb.frm));
        hi_a += int'(pwm_a);
        fr_a += int'(frame_a);
        hi_b += int'(pwm_b);
    endtask

    vec_t vecs[9];
    int   n;

    initial begin
        // High cycles in one 2496-cycle frame at PERIOD=156.
        vecs[0] = '{24'h0F_0000,  240};
        vecs[1] = '{24'h4E_0001, 1249};
        vecs[2] = '{24'h4E_8000, 1249};
        vecs[3] = '{24'h00_0000,    0};
        vecs[4] = '{24'h9C_0001, 2496};
        vecs[5] = '{24'hFF_FFFF, 2496};
        vecs[6] = '{24'h02_AAAA,   40};
        vecs[7] = '{24'h75_0000, 1872};
        vecs[8] = '{24'h9B_00FF, 2488};

        ma = '{0, 24'd0, 1'b0, 1'b0};
        mb = '{0, 24'd0, 1'b0, 1'b0};
        hi_a = 0; fr_a = 0; hi_b = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        cfg_a = 24'h0F_0000; cfg_b = 24'h02_AAAA;
        step();
        check("reset_pwm_a",   32'(pwm_a),   32'd0);
        check("reset_frame_a", 32'(frame_a), 32'd0);

        // Release both channels. Check the first rising edge, the frame spacing,
        // and the PERIOD=4 frame total.
        rst_a = 1'b0; rst_b = 1'b0;
        hi_b = 0;
        step();
        check("first_rise",  32'(pwm_a),   32'd1);
        check("first_frame", 32'(frame_a), 32'd1);
        n = 1;
        repeat (63) begin step(); n++; end
        check("b_hi_per_frame", 32'(hi_b), 32'd40);
        while (n < 3000) begin
            step();
            n++;
            if (frame_a) break;
        end
        check("frame_spacing", 32'(n - 1), 32'd2496);

        // Table: reset, load, then one full frame.
        for (int i = 0; i < 9; i++) begin
            rst_a = 1'b1;
            cfg_a = vecs[i].cfg;
            step();
            rst_a = 1'b0;
            hi_a = 0; fr_a = 0;
            repeat (2496) step();
            check("vec_hi_per_frame", 32'(hi_a), 32'(vecs[i].exp_hi));
            check("vec_frames",       32'(fr_a), 32'd1);
        end

        // A mid-frame change is deferred to the next frame.
        rst_a = 1'b1; cfg_a = 24'h0F_0000;
        step();
        rst_a = 1'b0; hi_a = 0;
        step();
        repeat (1101) step();
        cfg_a = 24'h75_0000;
        repeat (1394) step();
        check("mid_change_old", 32'(hi_a), 32'd240);
        hi_a = 0;
        repeat (2496) step();
        check("mid_change_new", 32'(hi_a), 32'd1872);

        // Reset at cnt=50, bcnt=9 aborts the frame.
        rst_a = 1'b1; cfg_a = 24'h9C_0000;
        step();
        rst_a = 1'b0;
        step();
        repeat (1453) step();
        rst_a = 1'b1;
        step();
        check("midrst_pwm",   32'(pwm_a),   32'd0);
        check("midrst_frame", 32'(frame_a), 32'd0);
        rst_a = 1'b0; hi_a = 0; fr_a = 0;
        step();
        check("midrst_reload", 32'(frame_a), 32'd1);
        check("midrst_high",   32'(pwm_a),   32'd1);
        repeat (2495) step();
        check("midrst_hi_frame", 32'(hi_a), 32'd2496);
        check("midrst_frames",   32'(fr_a), 32'd1);

        // Random settings, hold times and reset pulses.
        for (int s = 0; s < 30; s++) begin
            rst_a = ($urandom_range(0, 7) == 0);
            rst_b = ($urandom_range(0, 7) == 0);
            cfg_a = 24'($urandom());
            cfg_b = 24'($urandom());
            case ($urandom_range(0, 3))
                0: cfg_a[23:16] = 8'd155;
                1: cfg_a[23:16] = 8'd156;
                2: cfg_a[23:16] = 8'(($urandom_range(0, 2)));
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) cfg_b[23:16] = 8'($urandom_range(0, 5));
            repeat ($urandom_range(1, 600)) begin
                step();
                rst_a = 1'b0;
                rst_b = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
